cfg_scan_loader: RTL and testbench

CFG_SCAN_LOADER -- requirements
Module: cfg_scan_loader

---
 rtl/cfg_scan_loader.sv | 199 +++++++++++++++++++
 tb/tb_cfg_scan_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_scan_loader.sv
// cfg_scan_loader: serialises tile configuration commands onto a scan chain.
// Frame commands (WR/COMMIT) shift a 39-bit SRAM frame followed by
// CLB_CHAIN_LEN zeros and then hold. LUT commands shift a 32-bit word and can
// strobe the CLB config latch.
// Optional macro CFG_SCAN_LOADER_READBACK_EN: captures the previous frame from
// cfg_scan_out while a new frame is shifted in.
module cfg_scan_loader #(
    parameter int CLB_CHAIN_LEN = 64,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic        cfg_clk,
    input  logic        cfg_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_last,
    output logic        busy,
    output logic        cfg_scan_en,
    output logic        cfg_scan_in,
    output logic        cfg_lut_we,
    input  logic        cfg_scan_out,
    output logic        rd_valid,
    output logic [38:0] rd_data
);

    localparam int FRAME_W = 39;
    localparam int SHIFT_L = FRAME_W + CLB_CHAIN_LEN;
    localparam int CNT_MAX = (SHIFT_L > HOLD_CYCLES) ? SHIFT_L : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(SHIFT_L - 1);
    localparam logic [CNT_W-1:0] LUT_LAST   = CNT_W'(31);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] RB_LAST    = CNT_W'(FRAME_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_WE    = 2'd3;

    localparam logic [1:0] OP_WR     = 2'b00;
    localparam logic [1:0] OP_COMMIT = 2'b01;
    localparam logic [1:0] OP_LUT    = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_lut_q, is_lut_d;
    logic               last_q, last_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               scan_en_q, scan_en_d;
    logic               scan_in_q, scan_in_d;
    logic               lut_we_q, lut_we_d;
    logic               rb_done;
    logic [FRAME_W-1:0] frame;

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = ~cmd_ready;
    assign cfg_scan_en = scan_en_q;
    assign cfg_scan_in = scan_in_q;
    assign cfg_lut_we  = lut_we_q;

    // Build the SRAM frame for the offered command: {data, csb, oeb, web, addr}.
    always_comb begin
        frame = {cmd_data, 1'b0, 1'b1, 1'b0, cmd_addr};
        if (cmd_op == OP_COMMIT) begin
            frame = {32'h0, 1'b1, 1'b0, 1'b0, cmd_addr};
        end
    end

    // Sequencer: the first scan bit is loaded at acceptance so the outputs stay registered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_lut_d  = is_lut_q;
        last_d    = last_q;
        sh_d      = sh_q;
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
        lut_we_d  = 1'b0;
        rb_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WR, OP_COMMIT: begin
                            state_d   = S_SHIFT;
                            cnt_d     = '0;
                            is_lut_d  = 1'b0;
                            last_d    = 1'b0;
                            sh_d      = {frame[FRAME_W-2:0], 1'b0};
                            scan_en_d = 1'b1;
                            scan_in_d = frame[FRAME_W-1];
                        end
                        OP_LUT: begin
                            state_d   = S_SHIFT;
                            cnt_d     = '0;
                            is_lut_d  = 1'b1;
                            last_d    = cmd_last;
                            sh_d      = {cmd_data[30:0], 8'h00};
                            scan_en_d = 1'b1;
                            scan_in_d = cmd_data[31];
                        end
                        default: begin
                            // NOP: consumed without leaving IDLE.
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                if (cnt_q == (is_lut_q ? LUT_LAST : FRAME_LAST)) begin
                    cnt_d = '0;
                    if (is_lut_q) begin
                        if (last_q) begin
                            state_d  = S_WE;
                            lut_we_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        rb_done = 1'b1;
                        state_d = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
                    end
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    scan_en_d = 1'b1;
                    scan_in_d = sh_q[FRAME_W-1];
                    sh_d      = {sh_q[FRAME_W-2:0], 1'b0};
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer and scan output registers.
    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_lut_q  <= 1'b0;
            last_q    <= 1'b0;
            sh_q      <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            lut_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_lut_q  <= is_lut_d;
            last_q    <= last_d;
            sh_q      <= sh_d;
            scan_en_q <= scan_en_d;
            scan_in_q <= scan_in_d;
            lut_we_q  <= lut_we_d;
        end
    end

`ifdef CFG_SCAN_LOADER_READBACK_EN
    logic               rd_valid_q;
    logic [FRAME_W-1:0] rd_data_q;

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    // The old frame leaves the tile on the first 39 shift edges, oldest MSB first.
    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rb_done;
            if (state_q == S_SHIFT && !is_lut_q && cnt_q <= RB_LAST) begin
                rd_data_q <= {rd_data_q[FRAME_W-2:0], cfg_scan_out};
            end
        end
    end
`else
    logic unused_rb;

    assign unused_rb = ^{cfg_scan_out, rb_done, RB_LAST};
    assign rd_valid  = 1'b0;
    assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Self-checking bench for cfg_scan_loader with a behavioural tile model
// (scan chain, SRAM rows, config rows, CLB latch).
// Honours CFG_SCAN_LOADER_READBACK_EN when it is defined for the build.
module tb_cfg_scan_loader;

    localparam int CLB  = 64;
    localparam int HOLD = 2;
    localparam int FW   = 39;
    localparam int L    = FW + CLB;

    logic        cfg_clk = 1'b0;
    logic        cfg_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b11;
    logic [3:0]  cmd_addr = 4'h0;
    logic [31:0] cmd_data = 32'h0;
    logic        cmd_last = 1'b0;
    logic        busy;
    logic        cfg_scan_en;
    logic        cfg_scan_in;
    logic        cfg_lut_we;
    logic        cfg_scan_out;
    logic        rd_valid;
    logic [38:0] rd_data;

    int checks = 0;
    int failures = 0;

    always #5 cfg_clk = ~cfg_clk;

    cfg_scan_loader #(.CLB_CHAIN_LEN(CLB), .HOLD_CYCLES(HOLD)) dut (
        .cfg_clk(cfg_clk), .cfg_rst_n(cfg_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .busy(busy), .cfg_scan_en(cfg_scan_en), .cfg_scan_in(cfg_scan_in),
        .cfg_lut_we(cfg_lut_we), .cfg_scan_out(cfg_scan_out),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    // ---------------- tile model ----------------
    logic [L-1:0] chain = '0;
    int           run_len = 0;
    logic [31:0]  sram [16];
    logic [31:0]  cfgrow [16];
    logic [31:0]  clb_latch = 32'h0;
    logic [38:0]  fr;

    assign cfg_scan_out = chain[L-1];
    assign fr = chain[L-1 -: FW];

    always @(posedge cfg_clk) begin
        if (cfg_scan_en) begin
            chain   <= {chain[L-2:0], cfg_scan_in};
            run_len <= run_len + 1;
        end else begin
            if (run_len == L) begin
                if (!fr[6] && !fr[4]) sram[fr[3:0]] <= fr[38:7];
                else if (fr[6]) cfgrow[fr[3:0]] <= sram[fr[3:0]];
            end
            run_len <= 0;
        end
        if (cfg_lut_we) clb_latch <= chain[31:0];
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_sram [16];
    logic [31:0] ref_cfg [16];
    logic [38:0] last_rd;

    function automatic logic [127:0] model_stream(input logic [1:0] op, input logic [3:0] addr,
                                                  input logic [31:0] data);
        logic [38:0] f;
        case (op)
            2'b00: f = {data, 3'b010, addr};
            2'b01: f = {32'h0, 3'b100, addr};
            2'b10: return {96'h0, data};
            default: return '0;
        endcase
        return {89'h0, f} << CLB;
    endfunction

    function automatic int model_en(input logic [1:0] op);
        return (op == 2'b00 || op == 2'b01) ? L : (op == 2'b10) ? 32 : 0;
    endfunction

    function automatic int model_busy(input logic [1:0] op, input logic last);
        return (op == 2'b00 || op == 2'b01) ? L + HOLD : (op == 2'b10) ? 32 + int'(last) : 0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one command, trace outputs until cmd_ready returns, compare.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data,
                           input logic last, input int exp_en, input int exp_busy, input int exp_we,
                           input string tag);
        logic [127:0] act_bits;
        logic [38:0]  snap;
        logic [38:0]  rd_cap;
        int en_cnt, first_en, last_en, we_cnt, we_at, ready_at, rv_cnt, bad_busy, overlap, n;
        act_bits = '0; rd_cap = '0;
        en_cnt = 0; first_en = -1; last_en = -1; we_cnt = 0; we_at = -1;
        ready_at = -1; rv_cnt = 0; bad_busy = 0; overlap = 0;
        @(negedge cfg_clk);
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_last = last; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge cfg_clk);
            n++;
        end
        chk($sformatf("%s_accept_wait", tag), 128'(cmd_ready), 128'(1));
        snap = fr;
        @(posedge cfg_clk);
        #1 cmd_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge cfg_clk);
            if (cfg_scan_en) begin
                act_bits = {act_bits[126:0], cfg_scan_in};
                if (first_en < 0) first_en = c;
                last_en = c;
                en_cnt++;
            end
            if (cfg_lut_we) begin
                we_cnt++;
                we_at = c;
            end
            if (cfg_scan_en && cfg_lut_we) overlap++;
            if (busy !== !cmd_ready) bad_busy++;
            if (rd_valid) begin
                rv_cnt++;
                rd_cap = rd_data;
            end
            if (cmd_ready) begin
                ready_at = c;
                break;
            end
        end
        chk($sformatf("%s_en_cnt", tag), 128'(en_cnt), 128'(exp_en));
        chk($sformatf("%s_bits", tag), act_bits, model_stream(op, addr, data));
        if (exp_en > 0) begin
            chk($sformatf("%s_en_start", tag), 128'(first_en), 128'(0));
            chk($sformatf("%s_en_contig", tag), 128'(last_en - first_en + 1), 128'(exp_en));
        end
        chk($sformatf("%s_busy_len", tag), 128'(ready_at), 128'(exp_busy));
        chk($sformatf("%s_we_cnt", tag), 128'(we_cnt), 128'(exp_we));
        if (exp_we > 0) chk($sformatf("%s_we_at", tag), 128'(we_at), 128'(32));
        chk($sformatf("%s_busy_inv", tag), 128'(bad_busy), 128'(0));
        chk($sformatf("%s_en_we_overlap", tag), 128'(overlap), 128'(0));
`ifdef CFG_SCAN_LOADER_READBACK_EN
        chk($sformatf("%s_rv_cnt", tag), 128'(rv_cnt), 128'((op == 2'b00 || op == 2'b01) ? 1 : 0));
        if (rv_cnt > 0) begin
            chk($sformatf("%s_rd_data", tag), 128'(rd_cap), 128'(snap));
            last_rd = rd_cap;
        end
`else
        chk($sformatf("%s_rv_cnt", tag), 128'(rv_cnt), 128'(0));
        chk($sformatf("%s_rd_data_zero", tag), 128'(rd_data), 128'(0));
`endif
        case (op)
            2'b00: begin
                ref_sram[addr] = data;
                chk($sformatf("%s_sram", tag), 128'(sram[addr]), 128'(ref_sram[addr]));
            end
            2'b01: begin
                ref_cfg[addr] = ref_sram[addr];
                chk($sformatf("%s_cfgrow", tag), 128'(cfgrow[addr]), 128'(ref_cfg[addr]));
            end
            2'b10: if (last) chk($sformatf("%s_clb_latch", tag), 128'(clb_latch), 128'(data));
            default: ;
        endcase
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        last;
        int          exp_en;
        int          exp_busy;
        int          exp_we;
    } vec_t;

    vec_t        vt [6];
    logic [38:0] rd_hist [6];

    initial begin
        int acc, runs, cur, badlen, en_rdy, bad_inv, we_seen, en_seen;
        logic prev_en, done;
        for (int i = 0; i < 16; i++) begin
            sram[i] = '0; cfgrow[i] = '0; ref_sram[i] = '0; ref_cfg[i] = '0;
        end
        last_rd = '0;
        vt[0] = '{2'b00, 4'd3,  32'hDEADBEEF, 1'b0, L,  L + HOLD, 0};
        vt[1] = '{2'b01, 4'd3,  32'h00000000, 1'b0, L,  L + HOLD, 0};
        vt[2] = '{2'b10, 4'd0,  32'hA5A50001, 1'b1, 32, 33,       1};
        vt[3] = '{2'b10, 4'd0,  32'hA5A50001, 1'b0, 32, 32,       0};
        vt[4] = '{2'b11, 4'd5,  32'h12345678, 1'b1, 0,  0,        0};
        vt[5] = '{2'b00, 4'd15, 32'h00000001, 1'b0, L,  L + HOLD, 0};

        // reset state
        #12;
        chk("rst_scan_en", 128'(cfg_scan_en), 128'(0));
        chk("rst_lut_we", 128'(cfg_lut_we), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        @(negedge cfg_clk);
        cfg_rst_n = 1'b1;
        @(posedge cfg_clk);
        #1;
        chk("rst_ready", 128'(cmd_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));

        // directed table
        for (int i = 0; i < 6; i++) begin
            run_cmd(vt[i].op, vt[i].addr, vt[i].data, vt[i].last, vt[i].exp_en, vt[i].exp_busy,
                    vt[i].exp_we, $sformatf("vec%0d", i));
            rd_hist[i] = last_rd;
        end
        chk("commit_row3", 128'(cfgrow[3]), 128'(32'hDEADBEEF));
`ifdef CFG_SCAN_LOADER_READBACK_EN
        chk("rb_first_frame", 128'(rd_hist[1]), 128'({32'hDEADBEEF, 3'b010, 4'h3}));
`endif

        // back-to-back WR with cmd_valid held
        @(negedge cfg_clk);
        cmd_op = 2'b00; cmd_addr = 4'd7; cmd_data = 32'hCAFEF00D; cmd_last = 1'b0; cmd_valid = 1'b1;
        acc = 0; runs = 0; cur = 0; badlen = 0; en_rdy = 0; bad_inv = 0; prev_en = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (cfg_scan_en && !prev_en) begin runs++; cur = 0; end
            if (cfg_scan_en) cur++;
            if (!cfg_scan_en && prev_en && cur != L) badlen++;
            if (cfg_scan_en && cmd_ready) en_rdy++;
            if (busy !== !cmd_ready) bad_inv++;
            prev_en = cfg_scan_en;
            if (cmd_valid && cmd_ready) begin
                acc++;
                if (acc == 2) begin
                    @(posedge cfg_clk);
                    #1 cmd_valid = 1'b0;
                end
            end
            done = (acc == 2 && !cmd_valid && cmd_ready && !cfg_scan_en);
            @(negedge cfg_clk);
        end
        chk("b2b_done", 128'(done), 128'(1));
        chk("b2b_accepts", 128'(acc), 128'(2));
        chk("b2b_runs", 128'(runs), 128'(2));
        chk("b2b_runlen", 128'(badlen), 128'(0));
        chk("b2b_en_while_ready", 128'(en_rdy), 128'(0));
        chk("b2b_busy_inv", 128'(bad_inv), 128'(0));
        ref_sram[7] = 32'hCAFEF00D;
        chk("b2b_sram", 128'(sram[7]), 128'(ref_sram[7]));

        // reset at shift cycle 50
        @(negedge cfg_clk);
        cmd_op = 2'b00; cmd_addr = 4'd9; cmd_data = 32'h12345678; cmd_last = 1'b1; cmd_valid = 1'b1;
        @(posedge cfg_clk);
        #1 cmd_valid = 1'b0;
        repeat (50) @(posedge cfg_clk);
        #1;
        chk("mid_pre_en", 128'(cfg_scan_en), 128'(1));
        #1 cfg_rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 128'(cfg_scan_en), 128'(0));
        chk("mid_rst_in", 128'(cfg_scan_in), 128'(0));
        chk("mid_rst_we", 128'(cfg_lut_we), 128'(0));
        chk("mid_rst_rv", 128'(rd_valid), 128'(0));
        chk("mid_rst_rd", 128'(rd_data), 128'(0));
        repeat (2) @(negedge cfg_clk);
        cfg_rst_n = 1'b1;
        @(posedge cfg_clk);
        #1;
        chk("mid_rel_ready", 128'(cmd_ready), 128'(1));
        we_seen = 0; en_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge cfg_clk);
            if (cfg_lut_we) we_seen++;
            if (cfg_scan_en) en_seen++;
        end
        chk("mid_no_we", 128'(we_seen), 128'(0));
        chk("mid_no_en", 128'(en_seen), 128'(0));
        chk("mid_sram_untouched", 128'(sram[9]), 128'(ref_sram[9]));

        // randomized commands against the reference model
        for (int i = 0; i < 16; i++) begin
            logic [1:0]  op;
            logic [3:0]  addr;
            logic [31:0] data;
            logic        last;
            op   = 2'($urandom_range(0, 3));
            addr = 4'($urandom_range(0, 15));
            data = $urandom;
            last = 1'($urandom_range(0, 1));
            run_cmd(op, addr, data, last, model_en(op), model_busy(op, last),
                    (op == 2'b10 && last) ? 1 : 0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
